// File: rtl/rr_hold_arbiter_pkg.sv
// ============================================================================
// Module   : rr_arb_pkg
// Brief    : Shared types and helpers for the round-robin hold arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_arb_pkg;

    localparam int c_MAX_N = 64;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Index of the set bit; the caller guarantees at most one bit is set.
    function automatic logic [5:0] onehot_to_idx(input logic [c_MAX_N-1:0] oh);
        logic [5:0] idx;
        idx = '0;
        for (int i = 0; i < c_MAX_N; i++) begin
            if (oh[i]) idx = idx | 6'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_hold_arbiter_fixed_prio_arb.sv
// ============================================================================
// Module   : fixed_prio_arb
// Brief    : Combinational lowest-index-wins selector, one-hot result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fixed_prio_arb #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_gnt
);

    // Two's-complement trick isolates the lowest set bit.
    assign o_gnt = i_req & (~i_req + N'(1));

endmodule

`default_nettype wire

// File: rtl/rr_hold_arbiter.sv
// ============================================================================
// Module   : rr_hold_arbiter
// Brief    : Round-robin arbiter whose grant is held while the owner requests.
//            Optional macro RR_HOLD_ARBITER_BURST_LIMIT_EN caps each tenure
//            at MAX_BURST cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_hold_arbiter
    import rr_arb_pkg::*;
#(
    parameter  int N         = 32,
    parameter  int MAX_BURST = 16,
    localparam int IDW       = id_width(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] gnt_id_o,
    output logic           busy_o
);

    localparam logic [IDW-1:0] c_LAST = IDW'(N - 1);

    arb_state_t     r_state;
    logic [IDW-1:0] r_ptr;
    logic [N-1:0]   r_gnt;
    logic [IDW-1:0] r_gnt_id;
    logic           r_busy;

    logic [N-1:0]   w_mask;
    logic [N-1:0]   w_gnt_masked;
    logic [N-1:0]   w_gnt_plain;
    logic [N-1:0]   w_win;
    logic [IDW-1:0] w_win_idx;
    logic [IDW-1:0] w_next_ptr;
    logic           w_any_req;
    logic           w_owner_req;
    logic           w_burst_hit;
    logic           w_hold;

    for (genvar i = 0; i < N; i++) begin : g_mask
        assign w_mask[i] = (IDW'(i) >= r_ptr);
    end

    fixed_prio_arb #(.N(N)) u_masked (
        .i_req (req_i & w_mask),
        .o_gnt (w_gnt_masked)
    );

    fixed_prio_arb #(.N(N)) u_plain (
        .i_req (req_i),
        .o_gnt (w_gnt_plain)
    );

    assign w_win       = (|w_gnt_masked) ? w_gnt_masked : w_gnt_plain;
    assign w_win_idx   = IDW'(onehot_to_idx(c_MAX_N'(w_win)));
    assign w_next_ptr  = (w_win_idx == c_LAST) ? '0 : w_win_idx + IDW'(1);
    assign w_any_req   = |req_i;
    assign w_owner_req = |(req_i & r_gnt);
    assign w_hold      = (r_state == ARB_OWNED) && w_owner_req && !w_burst_hit;

`ifdef RR_HOLD_ARBITER_BURST_LIMIT_EN
    localparam int c_BURST_W = $clog2(MAX_BURST);

    logic [c_BURST_W-1:0] r_burst;

    // Counts completed grant cycles of the current tenure; zero on a new grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_burst <= '0;
        end else if (w_hold) begin
            r_burst <= r_burst + c_BURST_W'(1);
        end else begin
            r_burst <= '0;
        end
    end

    assign w_burst_hit = (r_burst == c_BURST_W'(MAX_BURST - 1));
`else
    assign w_burst_hit = 1'b0;
`endif

    // A forced end of tenure re-arbitrates exactly like a release.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ARB_IDLE;
            r_ptr    <= '0;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_busy   <= 1'b0;
        end else if (!w_hold) begin
            if (w_any_req) begin
                r_state  <= ARB_OWNED;
                r_gnt    <= w_win;
                r_gnt_id <= w_win_idx;
                r_ptr    <= w_next_ptr;
                r_busy   <= 1'b1;
            end else begin
                r_state  <= ARB_IDLE;
                r_gnt    <= '0;
                r_gnt_id <= '0;
                r_busy   <= 1'b0;
            end
        end
    end

    assign gnt_o    = r_gnt;
    assign gnt_id_o = r_gnt_id;
    assign busy_o   = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_rr_hold_arbiter.sv
// ============================================================================
// Module   : tb_rr_hold_arbiter
// Brief    : Scoreboard bench for rr_hold_arbiter (N=4, MAX_BURST=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_hold_arbiter;

    localparam int N   = 4;
    localparam int MB  = 4;
`ifdef RR_HOLD_ARBITER_BURST_LIMIT_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [1:0]   id;
        logic         busy;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req_i;
    logic [N-1:0] gnt_o;
    logic [1:0]   gnt_id_o;
    logic         busy_o;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;
    bit   done    = 1'b0;

    // Reference model: owner index (-1 idle), rotating pointer, tenure length.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;

    rr_hold_arbiter #(.N(N), .MAX_BURST(MB)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .gnt_id_o (gnt_id_o),
        .busy_o   (busy_o)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic [N-1:0] r, input logic rst);
        int win;
        bit keep;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0;
        end else begin
            keep = (m_owner >= 0) && r[m_owner] && !(BURST && m_cnt == MB - 1);
            if (keep) begin
                m_cnt++;
            end else begin
                win = -1;
                for (int k = 0; k < N; k++) begin
                    if (win < 0 && r[(m_ptr + k) % N]) win = (m_ptr + k) % N;
                end
                m_cnt = 0;
                m_owner = win;
                if (win >= 0) m_ptr = (win + 1) % N;
            end
        end
    endtask

    // Drive one cycle's inputs at the falling edge and queue the expected result.
    task automatic cyc(input logic [N-1:0] r, input logic rst);
        exp_t e;
        @(negedge clk);
        req_i = r;
        reset = rst;
        model_step(r, rst);
        e.gnt  = (m_owner >= 0) ? N'(1) << m_owner : '0;
        e.id   = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        e.busy = (m_owner >= 0);
        exp_q.push_back(e);
    endtask

    task automatic repeat_req(input logic [N-1:0] r, input int n);
        for (int i = 0; i < n; i++) cyc(r, 1'b0);
    endtask

    // Monitor: compares every registered output one step after each rising edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (gnt_o !== e.gnt) begin
                    errors++;
                    $display("FAIL gnt t=%0t got=%b want=%b", $time, gnt_o, e.gnt);
                end
                if (gnt_id_o !== e.id) begin
                    errors++;
                    $display("FAIL gnt_id t=%0t got=%0d want=%0d", $time, gnt_id_o, e.id);
                end
                if (busy_o !== e.busy) begin
                    errors++;
                    $display("FAIL busy t=%0t got=%b want=%b", $time, busy_o, e.busy);
                end
            end
        end
    end

    initial begin : stimulus
        logic [N-1:0] r;
        req_i = '0;
        reset = 1'b1;

        // Reset held with all requesters active, then release.
        cyc(4'b1111, 1'b1);
        cyc(4'b1111, 1'b1);
        repeat_req(4'b1111, 2);

        // Rotation: each owner drops its request on its third granted cycle.
        for (int i = 0; i < 24; i++) begin
            r = 4'b1111;
            if (m_owner >= 0 && m_cnt == 2) r[m_owner] = 1'b0;
            cyc(r, 1'b0);
        end

        // Hold with a competing request, then release to index 0.
        repeat_req(4'b0000, 2);
        repeat_req(4'b0100, 20);
        repeat_req(4'b0101, 3);
        repeat_req(4'b0001, 3);

        // Wrap and idle: owner 3 releases into silence, then 1001 picks 0.
        repeat_req(4'b0000, 2);
        repeat_req(4'b1000, 3);
        repeat_req(4'b0000, 3);
        repeat_req(4'b1001, 3);

        // Burst limiting (or unlimited hold when not compiled in).
        repeat_req(4'b0000, 2);
        repeat_req(4'b0011, 20);
        repeat_req(4'b0001, 10);

        // Reset in the middle of index 1's tenure.
        repeat_req(4'b0000, 2);
        repeat_req(4'b0010, 2);
        repeat_req(4'b0110, 2);
        cyc(4'b0110, 1'b1);
        repeat_req(4'b0110, 3);

        // Randomised sticky requesters with occasional reset.
        r = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            cyc(r, ($urandom_range(0, 299) == 0));
        end

        cyc('0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        if (!done) begin
            $display("FAIL timeout vectors=%0d want=complete", vectors);
            $fatal(1, "timeout");
        end
    end

endmodule

`default_nettype wire

// File: doc/rr_hold_arbiter.md
# rr_hold_arbiter

Round-robin arbiter with grant hold for sharing one resource among N requesters. A grant is registered and held for as long as its owner keeps requesting. On release it moves, with no idle bubble, to the next requester in rotating order. It sits in front of shared datapath resources (bus port, memory bank, execution unit) where single-cycle fixed-priority selection would starve high-index requesters.

## Interface
- N, default 32: number of requesters; legal range 1..64.
- MAX_BURST, default 16: maximum consecutive grant cycles per tenure when burst limiting is compiled in; legal range 2..256.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_i  input  N  request vector; bit i held high by requester i while it wants or uses the resource.
- gnt_o  output  N  registered one-hot grant; all zero when idle.
- gnt_id_o  output  IDW  binary index of current owner, IDW = max(1, clog2(N)); 0 when idle.
- busy_o  output  1  high while any grant is asserted.

## Operation
- State: IDLE or OWNED. Also held: owner index, priority pointer ptr (0..N-1), and burst counter when enabled.
- Reset values: gnt_o = 0, gnt_id_o = 0, busy_o = 0, state = IDLE, ptr = 0, burst counter = 0.
- Arbitration is a rotating priority search starting at ptr and wrapping at N-1 to 0. It is implemented as a masked pass (bits >= ptr) with an unmasked fallback pass. The first set bit wins.
- IDLE:
  - If any req_i bit is set, grant the winner, go to OWNED, and set ptr = winner+1 mod N.
  - Otherwise stay IDLE.
- OWNED, with req_i[owner] still high (and burst limit not hit): hold the grant unchanged. ptr is unchanged. Other requests are ignored.
- OWNED, with req_i[owner] low (release):
  - Re-arbitrate the same cycle over the current req_i.
  - If there is a winner, grant it directly (OWNED to OWNED, no bubble) and set ptr = winner+1.
  - If there is none, go to IDLE with gnt_o = 0.
- Fairness: a requester that has just been served has lowest priority in the next arbitration.
- N = 1: ptr is constant 0. The grant simply follows req_i[0] with one cycle of latency.
- gnt_o is always one-hot or zero. No two bits are ever set.

## Timing
- Grant latency: req_i sampled high at edge k with the block IDLE gives gnt_o high from edge k onward, i.e. visible in the cycle after the request is first presented.
- Release: req_i[owner] sampled low at edge k means gnt_o[owner] drops at edge k. The owner therefore sees exactly one trailing cycle of grant after dropping its request.
- Handover: the new owner's grant appears at the same edge k. There are zero idle cycles between tenures.
- Simultaneous new requests arriving at the release edge take part in that arbitration.
- Reset asserted mid-tenure: at the next edge all outputs go to zero and ptr goes to 0, regardless of req_i.
- The block has no combinational path from req_i to any output.

## Configuration
- Macro: RR_HOLD_ARBITER_BURST_LIMIT_EN.
- With the macro defined:
  - A counter counts the owner's granted cycles. It is cleared on each new grant.
  - When the counter reaches MAX_BURST-1 and the owner is still requesting, the tenure is forced to end. The block re-arbitrates exactly as on a release, with ptr already past the owner.
  - If the owner is the only requester it is re-granted, and its counter restarts.
  - Result: a tenure lasts at most MAX_BURST cycles.
- Without the macro: there is no counter, and a tenure lasts for as long as the owner requests. The MAX_BURST parameter is ignored.

## Structure
- Package rr_arb_pkg holds:
  - the state enum (ARB_IDLE, ARB_OWNED);
  - an id_width(N) function returning max(1, clog2(N));
  - a onehot_to_idx function.
- Sub-module fixed_prio_arb: parameterized N, purely combinational, returns the lowest-index set bit as one-hot. It is instantiated twice, for the masked pass and the unmasked pass.
- Top-level content: the state register, ptr, owner, burst counter and output registers.

## Test plan
- Reset and idle: N=4, reset held 2 cycles with req_i=4'b1111. The required response is gnt_o=0, busy_o=0 during reset; after release, gnt_o=4'b0001 one cycle later.
- Rotation: req_i=4'b1111, each owner drops its request 3 cycles after its grant and re-raises it next cycle. The grant order must be 0,1,2,3,0, with no idle cycle between grants.
- Hold: req_i[2] alone high for 20 cycles, then req_i[0] raised. gnt_o stays 4'b0100 until req_i[2] drops. gnt_o=4'b0001 at the release edge, with gnt_id_o=0.
- Wrap and idle: the owner is index 3 and releases while req_i=4'b0000. gnt_o goes to 0 and busy_o to 0. A later req_i=4'b1001 grants index 0 (ptr wrapped to 0).
- Burst limit (macro defined, MAX_BURST=4): req_i=4'b0011 held constantly. Grants alternate 0,1,0,1, each lasting exactly 4 cycles. With req_i=4'b0001 only, index 0 is re-granted continuously.
- Reset mid-tenure: index 1 is owned with req_i=4'b0110 and reset is pulsed for 1 cycle. All outputs are 0 at the next edge. Afterwards index 1 is granted first, because ptr=0 and bit 0 is not requesting.
